// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - borrow_in, LSB first,
// one bit per clock through a single borrow flop.
// Optional macro SUB_OVERFLOW_EN adds a registered two's-complement
// overflow output loaded alongside diff.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CW-1:0]    cnt;
`ifdef SUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    logic             a_i;
    logic             b_i;
    logic             d_i;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    // One full-subtractor cell acting on the current LSBs of the operand shifters
    always_comb begin
        a_i      = a_sh[0];
        b_i      = b_sh[0];
        d_i      = a_i ^ b_i ^ br;
        br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        res_next = {d_i, res_sh[WIDTH-1:1]};
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM with datapath shifters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        br     <= borrow_in;
                        res_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
`ifdef SUB_OVERFLOW_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    res_sh <= res_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        diff       <= res_next;
                        borrow_out <= br_next;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
`ifdef SUB_OVERFLOW_EN
                        overflow   <= (a_msb != b_msb) && (d_i != a_msb);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a latency-countdown model with
// arithmetic results, compared every cycle, plus literal spot checks.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .diff       (diff),
        .borrow_out (borrow_out),
`ifdef SUB_OVERFLOW_EN
        .overflow   (overflow),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request yields its arithmetic result W edges later
    int           rem = 0;
    logic [W-1:0] m_diff = '0;
    logic         m_bo = 1'b0;
    logic         m_ov = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] p_diff;
    logic         p_bo;
    logic         p_ov;

    always @(posedge clk) begin
        int t;
        if (rst) begin
            rem = 0; m_diff = '0; m_bo = 1'b0; m_ov = 1'b0;
            m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                rem--;
                if (rem == 0) begin
                    m_diff = p_diff; m_bo = p_bo; m_ov = p_ov;
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end else if (start) begin
                t      = int'(a) - int'(b) - int'(borrow_in);
                p_diff = W'(t);
                p_bo   = (t < 0);
                p_ov   = (a[W-1] != b[W-1]) && (p_diff[W-1] != a[W-1]);
                rem    = W;
                m_busy = 1'b1;
            end
        end
    end

    // Compare process: every output against the model on every cycle after reset
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("diff", 32'(diff), 32'(m_diff));
            check("borrow_out", 32'(borrow_out), 32'(m_bo));
`ifdef SUB_OVERFLOW_EN
            check("overflow", 32'(overflow), 32'(m_ov));
`endif
        end
    end

    // Present a request at the current negedge; returns one negedge after acceptance
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
        a = va; b = vb; borrow_in = vbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] ed, input logic ebo);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bo"}, 32'(borrow_out), 32'(ebo));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // 9 - 3: busy for W cycles, result in the DONE cycle, then held
        launch(4'd9, 4'd3, 1'b0);
        for (int k = 0; k < W; k++) begin
            check("busy_run", 32'(busy), 32'd1);
            @(negedge clk);
        end
        expect_result("sub9_3", 4'd6, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_diff", 32'(diff), 32'd6);

        launch(4'd3, 4'd9, 1'b0);
        repeat (W) @(negedge clk);
        expect_result("sub3_9", 4'hA, 1'b1);
        @(negedge clk);

        launch(4'd0, 4'd0, 1'b1);
        repeat (W) @(negedge clk);
        expect_result("sub0_0_b", 4'd15, 1'b1);
        @(negedge clk);

        // Start during busy is ignored; start in DONE is accepted back-to-back
        launch(4'd12, 4'd5, 1'b0);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W - 1) @(negedge clk);
        expect_result("ignore", 4'd7, 1'b0);
        launch(4'd5, 4'd5, 1'b0);
        repeat (W) @(negedge clk);
        expect_result("b2b", 4'd0, 1'b0);
        @(negedge clk);

        // Reset in the 2nd SHIFT cycle aborts without a done pulse
        launch(4'd9, 4'd3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bo", 32'(borrow_out), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (W + 2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        launch(4'd9, 4'd3, 1'b0);
        repeat (W) @(negedge clk);
        expect_result("after_abort", 4'd6, 1'b0);
        @(negedge clk);

`ifdef SUB_OVERFLOW_EN
        launch(4'd7, 4'd15, 1'b0);
        repeat (W) @(negedge clk);
        expect_result("ov7_15", 4'd8, 1'b1);
        check("ov7_15_ov", 32'(overflow), 32'd1);
        @(negedge clk);
        launch(4'd5, 4'd2, 1'b0);
        repeat (W) @(negedge clk);
        expect_result("ov5_2", 4'd3, 1'b0);
        check("ov5_2_ov", 32'(overflow), 32'd0);
        @(negedge clk);
`endif

        // Exhaustive sweep with random ignored starts and random gaps
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    launch(W'(ia), W'(ib), 1'(ic));
                    for (int k = 0; k < W - 1; k++) begin
                        start = 1'($urandom_range(0, 1));
                        a = W'($urandom); b = W'($urandom);
                        @(negedge clk);
                    end
                    start = 1'b0;
                    @(negedge clk);
                    check("sweep_done", 32'(done), 32'd1);
                    if ($urandom_range(0, 1) == 1) @(negedge clk);
                end
            end
        end

        // Random requests with free-running start noise
        repeat (600) begin
            start = 1'($urandom_range(0, 2) != 0);
            a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
